// File: rtl/qspi_tx_shifter.sv
// ---------------------------------------------------------------------------
// qspi_tx_shifter
//
// Transmit serialiser for the QSPI controller. Pops 32-bit words from the TX
// sync FIFO (written by the AHB side) and shifts them out on the QSPI data
// lines in single (IO0) or quad (IO3..IO0) mode. Generates SCLK (SPI mode 0,
// idle low) and CS_n. Stalls with SCLK low and CS_n asserted whenever the
// FIFO runs dry in the middle of a multi-word transfer.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle transfer request, only honoured in IDLE
//   quad_mode    1 = 4 bits per SCLK, 0 = IO0 only (latched at start)
//   clk_div      SCLK half-period = clk_div+1 clk cycles (latched at start)
//   num_words    number of FIFO words to send (latched at start)
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   FIFO pop request (combinational)
//   fifo_rd_data FIFO read data, valid one cycle after an accepted pop
//   sclk         QSPI serial clock
//   cs_n         chip select, active low
//   io_out       serial data out
//   io_oe        per-line output enables
//   busy         high from accepted start until done
//   done         one-cycle completion pulse
//
// Build option:
//   QSPI_TX_BYTE_SWAP_EN - when defined, each captured word is byte-reversed
//   so little-endian AHB data goes out byte 0 first, MSB-first within a byte.
// ---------------------------------------------------------------------------
module qspi_tx_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  quad_mode,
    input  logic [7:0]            clk_div,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  sclk,
    output logic                  cs_n,
    output logic [3:0]            io_out,
    output logic [3:0]            io_oe,
    output logic                  busy,
    output logic                  done
);

    localparam int UNIT_W = $clog2(DATA_WIDTH);
    localparam logic [UNIT_W-1:0] LAST_QUAD   = UNIT_W'(DATA_WIDTH / 4 - 1);
    localparam logic [UNIT_W-1:0] LAST_SINGLE = UNIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        FINISH
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [CNT_WIDTH-1:0]   words_left;
    logic                   quad_lat;
    logic [7:0]             div_lat;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  shift_next;
    logic [DATA_WIDTH-1:0]  load_word;
    logic [UNIT_W-1:0]      unit_cnt;
    logic [7:0]             half_cnt;
    logic                   half_wrap;
    logic                   sclk_fall;
    logic                   last_unit;

    logic                   sclk_r;
    logic                   cs_n_r;
    logic [3:0]             io_out_r;
    logic [3:0]             io_oe_r;
    logic                   busy_r;
    logic                   done_r;

`ifdef QSPI_TX_BYTE_SWAP_EN
    // Reverse byte order so byte 0 lands in the top byte and is shifted first.
    function automatic logic [DATA_WIDTH-1:0] byte_swap(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = w;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            r[i*8 +: 8] = w[DATA_WIDTH-8-i*8 +: 8];
        end
        return r;
    endfunction

    assign load_word = byte_swap(fifo_rd_data);
`else
    assign load_word = fifo_rd_data;
`endif

    // The pop request is purely combinational so a word is taken in the very
    // cycle the FIFO becomes non-empty; FETCH is left on that same edge, which
    // guarantees at most one pop per word.
    assign fifo_rd_en = (state == FETCH) && !fifo_empty;

    assign sclk   = sclk_r;
    assign cs_n   = cs_n_r;
    assign io_out = io_out_r;
    assign io_oe  = io_oe_r;
    assign busy   = busy_r;
    assign done   = done_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the shared timing strobes. The half-period counter
    // is reused in FINISH to time the CS_n hold-off, so half_wrap is meaningful
    // in both SHIFT and FINISH. A falling SCLK edge is the wrap point while SCLK
    // is currently high; that is where the next unit is presented.
    always_comb begin
        next_state = state;
        half_wrap  = (half_cnt == div_lat);
        sclk_fall  = (state == SHIFT) && half_wrap && sclk_r;
        last_unit  = quad_lat ? (unit_cnt == LAST_QUAD) : (unit_cnt == LAST_SINGLE);
        shift_next = quad_lat ? (shift_reg << 4) : (shift_reg << 1);

        case (state)
            IDLE: begin
                if (start && (num_words != '0)) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = SHIFT;
            end
            SHIFT: begin
                if (sclk_fall && last_unit) begin
                    next_state = (words_left == CNT_WIDTH'(1)) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                if (half_wrap) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. SCLK only ever toggles in SHIFT and the
    // transition out of SHIFT happens on a falling edge, so SCLK is low in every
    // other state without any extra gating. io_out is left untouched on the
    // final falling edge of a word so the lines hold steady through the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_left <= '0;
            quad_lat   <= 1'b0;
            div_lat    <= '0;
            shift_reg  <= '0;
            unit_cnt   <= '0;
            half_cnt   <= '0;
            sclk_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            io_out_r   <= '0;
            io_oe_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            words_left <= num_words;
                            quad_lat   <= quad_mode;
                            div_lat    <= clk_div;
                            busy_r     <= 1'b1;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    shift_reg <= load_word;
                    cs_n_r    <= 1'b0;
                    io_oe_r   <= quad_lat ? 4'hF : 4'b0001;
                    io_out_r  <= quad_lat ? load_word[DATA_WIDTH-1 -: 4]
                                          : {3'b000, load_word[DATA_WIDTH-1]};
                    half_cnt  <= '0;
                    unit_cnt  <= '0;
                end
                SHIFT: begin
                    if (half_wrap) begin
                        half_cnt <= '0;
                        sclk_r   <= ~sclk_r;
                        if (sclk_r) begin
                            if (last_unit) begin
                                words_left <= words_left - CNT_WIDTH'(1);
                                unit_cnt   <= '0;
                            end else begin
                                unit_cnt  <= unit_cnt + UNIT_W'(1);
                                shift_reg <= shift_next;
                                io_out_r  <= quad_lat ? shift_next[DATA_WIDTH-1 -: 4]
                                                      : {3'b000, shift_next[DATA_WIDTH-1]};
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                FINISH: begin
                    if (half_wrap) begin
                        cs_n_r   <= 1'b1;
                        io_oe_r  <= '0;
                        io_out_r <= '0;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_tx_shifter.sv
// ---------------------------------------------------------------------------
// tb_qspi_tx_shifter
//
// Directed bench for qspi_tx_shifter. A small FIFO model feeds words to the
// DUT; a behavioural model turns each pushed word into the list of values
// io_out must show at successive rising SCLK edges, and a monitor compares
// every rising edge against that list. Per-test literal expectations pin the
// model itself.
// ---------------------------------------------------------------------------
module tb_qspi_tx_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        quad_mode;
    logic [7:0]  clk_div;
    logic [15:0] num_words;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        sclk;
    logic        cs_n;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic        busy;
    logic        done;

    int          errors = 0;
    int          checks = 0;

    // FIFO model storage
    logic [31:0] fifo_mem [0:31];
    int          fifo_count = 0;
    int          rd_ptr = 0;
    int          pops = 0;

    // Behavioural model / monitor state
    logic [3:0]  exp_q [$];
    logic [3:0]  seen_q [$];
    logic        cur_quad = 1'b0;
    logic [7:0]  cur_div = 8'd0;
    int          rise_cnt = 0;
    int          done_cnt = 0;
    int          high_cnt = 0;
    logic        prev_sclk = 1'b0;

    qspi_tx_shifter #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .quad_mode    (quad_mode),
        .clk_div      (clk_div),
        .num_words    (num_words),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .io_out       (io_out),
        .io_oe        (io_oe),
        .busy         (busy),
        .done         (done)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fifo_empty = (rd_ptr >= fifo_count);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // FIFO model: data is presented one cycle after the pop, and a pop request
    // while empty is a protocol violation.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            checkOutput("pop while empty", {31'd0, fifo_empty}, 32'd0);
            if (!fifo_empty) begin
                fifo_rd_data <= fifo_mem[rd_ptr];
                rd_ptr       <= rd_ptr + 1;
                pops         <= pops + 1;
            end
        end
    end

    // Monitor: on each rising SCLK edge compare io_out/io_oe/cs_n against the
    // model, and on each falling edge check the high phase lasted clk_div+1.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sclk = 1'b0;
            high_cnt  = 0;
        end else begin
            if (sclk && !prev_sclk) begin
                rise_cnt++;
                high_cnt = 1;
                seen_q.push_back(io_out);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected sclk edge", 32'(rise_cnt), 32'd0);
                end else begin
                    checkOutput("io_out at rise", {28'd0, io_out}, {28'd0, exp_q.pop_front()});
                end
                checkOutput("io_oe at rise", {28'd0, io_oe}, cur_quad ? 32'hF : 32'h1);
                checkOutput("cs_n at rise", {31'd0, cs_n}, 32'd0);
            end else if (sclk) begin
                high_cnt++;
            end
            if (!sclk && prev_sclk) begin
                checkOutput("sclk high phase", 32'(high_cnt), 32'(cur_div) + 32'd1);
            end
            if (done) begin
                done_cnt++;
            end
            prev_sclk = sclk;
        end
    end

    // Behavioural model: the sequence of unit values one word produces.
    task automatic modelWord(input logic [31:0] w);
        logic [31:0] v;
        v = w;
`ifdef QSPI_TX_BYTE_SWAP_EN
        v = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        if (cur_quad) begin
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back(4'((v >> (28 - 4 * k)) & 32'hF));
            end
        end else begin
            for (int k = 0; k < 32; k++) begin
                exp_q.push_back({3'b000, v[31-k]});
            end
        end
    endtask

    task automatic pushWord(input logic [31:0] w);
        fifo_mem[fifo_count] = w;
        fifo_count++;
        modelWord(w);
    endtask

    task automatic clearCounters();
        rise_cnt = 0;
        done_cnt = 0;
        seen_q.delete();
    endtask

    // Drive a one-cycle start request from a negedge.
    task automatic applyStimulus(input logic q, input logic [7:0] div, input logic [15:0] n);
        quad_mode = q;
        clk_div   = div;
        num_words = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " done seen"}, {31'd0, done}, 32'd1);
        checkOutput({name, " busy low at done"}, {31'd0, busy}, 32'd0);
        checkOutput({name, " cs_n high at done"}, {31'd0, cs_n}, 32'd1);
        @(negedge clk);
        checkOutput({name, " done one cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [3:0] lit_quad [0:7];
        logic       lit_bits [0:7];
        int         pops_base;
        int         n;

`ifdef QSPI_TX_BYTE_SWAP_EN
        lit_quad = '{4'h7, 4'h8, 4'h5, 4'h6, 4'h3, 4'h4, 4'h1, 4'h2};
`else
        lit_quad = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
`endif
        lit_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n     = 1'b0;
        start     = 1'b0;
        quad_mode = 1'b0;
        clk_div   = 8'd0;
        num_words = 16'd0;
        repeat (3) @(negedge clk);

        // Reset values
        checkOutput("reset fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        checkOutput("reset sclk", {31'd0, sclk}, 32'd0);
        checkOutput("reset cs_n", {31'd0, cs_n}, 32'd1);
        checkOutput("reset io_out", {28'd0, io_out}, 32'd0);
        checkOutput("reset io_oe", {28'd0, io_oe}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: quad, clk_div=0, one word
        $display("[TB] quad single word");
        clearCounters();
        pops_base = pops;
        cur_quad  = 1'b1;
        cur_div   = 8'd0;
        pushWord(32'h12345678);
        applyStimulus(1'b1, 8'd0, 16'd1);
        checkOutput("t1 busy after start", {31'd0, busy}, 32'd1);
        waitDone(200, "t1");
        checkOutput("t1 rising edges", 32'(rise_cnt), 32'd8);
        checkOutput("t1 pops", 32'(pops - pops_base), 32'd1);
        checkOutput("t1 done pulses", 32'(done_cnt), 32'd1);
        checkOutput("t1 model drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t1 literal nibble", (i < seen_q.size()) ? {28'd0, seen_q[i]} : 32'hDEAD,
                        {28'd0, lit_quad[i]});
        end

        // Test 2: single, clk_div=1, 0xA5000000
        $display("[TB] single mode word");
        clearCounters();
        pops_base = pops;
        cur_quad  = 1'b0;
        cur_div   = 8'd1;
        pushWord(32'hA5000000);
        applyStimulus(1'b0, 8'd1, 16'd1);
        waitDone(1000, "t2");
        checkOutput("t2 rising edges", 32'(rise_cnt), 32'd32);
        checkOutput("t2 pops", 32'(pops - pops_base), 32'd1);
        for (int i = 0; i < 32; i++) begin
            checkOutput("t2 literal bit", (i < seen_q.size()) ? {28'd0, seen_q[i]} : 32'hDEAD,
                        (i < 8) ? {31'd0, lit_bits[i]} : 32'd0);
        end
        checkOutput("t2 io_oe idle", {28'd0, io_oe}, 32'd0);

        // Test 3: quad, two words, FIFO dry between them
        $display("[TB] quad two words with stall");
        clearCounters();
        pops_base = pops;
        cur_quad  = 1'b1;
        cur_div   = 8'd0;
        pushWord(32'hDEADBEEF);
        applyStimulus(1'b1, 8'd0, 16'd2);
        n = 0;
        while (pops - pops_base < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t3 first pop", 32'(pops - pops_base), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("t3 edges before stall", 32'(rise_cnt), 32'd8);
        for (int i = 0; i < 10; i++) begin
            checkOutput("t3 stall sclk", {31'd0, sclk}, 32'd0);
            checkOutput("t3 stall cs_n", {31'd0, cs_n}, 32'd0);
            checkOutput("t3 stall busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        pushWord(32'h0badcafe);
        #1;
        checkOutput("t3 pop on refill", {31'd0, fifo_rd_en}, 32'd1);
        waitDone(200, "t3");
        checkOutput("t3 rising edges", 32'(rise_cnt), 32'd16);
        checkOutput("t3 pops", 32'(pops - pops_base), 32'd2);
        checkOutput("t3 done pulses", 32'(done_cnt), 32'd1);
        checkOutput("t3 model drained", 32'(exp_q.size()), 32'd0);

        // Test 4: num_words = 0
        $display("[TB] zero word request");
        clearCounters();
        pops_base = pops;
        pushWord(32'h11111111);
        exp_q.delete();
        applyStimulus(1'b1, 8'd0, 16'd0);
        checkOutput("t4 done next cycle", {31'd0, done}, 32'd1);
        checkOutput("t4 busy", {31'd0, busy}, 32'd0);
        checkOutput("t4 cs_n", {31'd0, cs_n}, 32'd1);
        checkOutput("t4 no rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        checkOutput("t4 done one cycle", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("t4 no pop", 32'(pops - pops_base), 32'd0);
        checkOutput("t4 no edges", 32'(rise_cnt), 32'd0);
        // drop the unused word so later tests see only their own data
        fifo_count = rd_ptr;

        // Test 5: reset during third nibble
        $display("[TB] reset mid transfer");
        clearCounters();
        cur_quad = 1'b1;
        cur_div  = 8'd1;
        pushWord(32'hCAFEF00D);
        applyStimulus(1'b1, 8'd1, 16'd1);
        n = 0;
        while (rise_cnt < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5 reached third nibble", 32'(rise_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5 reset cs_n", {31'd0, cs_n}, 32'd1);
        checkOutput("t5 reset sclk", {31'd0, sclk}, 32'd0);
        checkOutput("t5 reset io_oe", {28'd0, io_oe}, 32'd0);
        checkOutput("t5 reset io_out", {28'd0, io_out}, 32'd0);
        checkOutput("t5 reset busy", {31'd0, busy}, 32'd0);
        checkOutput("t5 reset rd_en", {31'd0, fifo_rd_en}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        clearCounters();
        pops_base = pops;
        cur_div   = 8'd0;
        pushWord(32'h0F1E2D3C);
        applyStimulus(1'b1, 8'd0, 16'd1);
        waitDone(200, "t5");
        checkOutput("t5 rising edges", 32'(rise_cnt), 32'd8);
        checkOutput("t5 pops", 32'(pops - pops_base), 32'd1);
        checkOutput("t5 model drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/qspi_tx_shifter.md
Name: qspi_tx_shifter

Overview:
- Downstream consumer of the TX sync FIFO in the QSPI controller.
- Pops 32-bit words written by the AHB side and serialises them onto the QSPI data lines, in single (IO0) or quad (IO3..IO0) mode.
- Generates SCLK (SPI mode 0) and CS_n.
- Stalls cleanly when the FIFO runs dry mid-transfer.

Parameters:
- DATA_WIDTH, 32, FIFO word width; must be a multiple of 4.
- CNT_WIDTH, 16, width of the word-count input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- quad_mode  input  1  1 = quad (4 bits/SCLK), 0 = single (IO0 only); latched at start.
- clk_div  input  8  SCLK half-period = clk_div+1 clk cycles; latched at start.
- num_words  input  CNT_WIDTH  words to send; latched at start.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop request.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid 1 cycle after an accepted pop.
- sclk  output  1  QSPI serial clock, idle low.
- cs_n  output  1  chip select, active low.
- io_out  output  4  serial data out.
- io_oe  output  4  output enables.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: fifo_rd_en=0, sclk=0, cs_n=1, io_out=0, io_oe=0, busy=0, done=0. Internal state → IDLE, counters → 0.
- Reset asserted mid-transfer returns all outputs to reset values immediately. Any word already popped is discarded.
- IDLE, start=1, num_words≠0: latch num_words, quad_mode, clk_div; busy=1 next cycle; go FETCH.
- IDLE, start=1, num_words=0: done=1 for one cycle on the next cycle; no pop; cs_n stays 1; busy stays 0.
- start while busy=1: ignored.
- FETCH:
  - fifo_rd_en = (state==FETCH) && !fifo_empty, combinational.
  - If empty, remain in FETCH (stall). sclk is held 0; cs_n and io_out hold their values.
  - On pop, go LOAD.
- LOAD, one cycle: capture fifo_rd_data into the shift register.
  - cs_n←0.
  - io_oe←4'hF (quad) or 4'b0001 (single).
  - io_out←MS nibble (quad) or {3'b0, MSB} (single).
  - Reset half-period counter; go SHIFT.
- SHIFT:
  - Half-period counter counts 0..clk_div, then toggles sclk and wraps.
  - Rising edge (0→1): outputs unchanged; slave samples here.
  - Falling edge (1→0): advance to the next unit (nibble or bit).
  - Units per word: DATA_WIDTH/4 (quad) or DATA_WIDTH (single).
  - On the falling edge that ends the last unit: decrement words_left. If words_left≠0, go FETCH; else go FINISH.
  - sclk is 0 whenever the state is not SHIFT.
- FINISH:
  - Hold cs_n=0 for clk_div+1 cycles.
  - Then set cs_n=1, io_oe=0, io_out=0; done=1 for one cycle; busy=0 in the same cycle; go IDLE.
- Inter-word gap: at least 2 clk cycles (FETCH+LOAD) with sclk low and cs_n low. Longer if the FIFO is empty.
- words_left arithmetic is unsigned, CNT_WIDTH bits; full range 1..2^CNT_WIDTH-1 supported.
- At most one pop per word; never pops while fifo_empty=1.

Optional Feature:
- Macro: QSPI_TX_BYTE_SWAP_EN.
- Defined: the captured word is byte-reversed at LOAD, for little-endian AHB data. Byte 0 (bits 7:0) is shifted first, MSB-first within each byte.
- Undefined: the word is shifted MSB-first from bit DATA_WIDTH-1, with no reordering.

Test Plan:
- Quad mode, clk_div=0, num_words=1, FIFO holds 0x12345678:
  - Exactly one fifo_rd_en pulse.
  - io_out on 8 successive rising sclk edges = 1,2,3,4,5,6,7,8.
  - sclk period = 2 clk cycles; done pulses once; cs_n returns to 1.
- Single mode, clk_div=1, word 0xA5000000:
  - io_out[0] at the first 8 rising edges = 1,0,1,0,0,1,0,1, then 24 zeros; 32 rising edges total.
  - sclk half-period = 2 cycles; io_oe=4'b0001.
- Quad mode, num_words=2, FIFO empty after the first word for 10 cycles:
  - Exactly 8 edges, then sclk held 0 with cs_n=0 throughout the stall.
  - The second word pops when fifo_empty falls; 16 rising edges total; one done pulse.
- start with num_words=0:
  - done=1 on the next cycle; fifo_rd_en never asserts; cs_n=1; busy=0.
- rst_n pulled low during SHIFT of the 3rd nibble:
  - Immediately: cs_n=1, sclk=0, io_oe=0, busy=0.
  - After release, a new start transfers correctly.
- QSPI_TX_BYTE_SWAP_EN defined, quad mode, word 0x12345678:
  - Nibble order on io_out = 7,8,5,6,3,4,1,2.
